// File: rtl/cpu_seq_ctrl_pkg.sv
// Shared encodings for the ONC-16 control sequencer: state codes, op classes
// and the timeout counter width helper.
package cpu_seq_ctrl_pkg;

    localparam int OPC_W = 3;
    localparam int SEQ_W = 3;

    typedef enum logic [SEQ_W-1:0] {
        SEQ_IDLE   = 3'd0,
        SEQ_FETCH  = 3'd1,
        SEQ_DECODE = 3'd2,
        SEQ_EXEC   = 3'd3,
        SEQ_MEM    = 3'd4,
        SEQ_BRANCH = 3'd5,
        SEQ_HALT   = 3'd6,
        SEQ_ERR    = 3'd7
    } seq_state_t;

    typedef enum logic [OPC_W-1:0] {
        OPC_ALU  = 3'd0,
        OPC_LD   = 3'd1,
        OPC_ST   = 3'd2,
        OPC_BR   = 3'd3,
        OPC_NOP  = 3'd4,
        OPC_HALT = 3'd5
    } op_class_t;

    // Counter width able to hold 0..n, never narrower than one bit.
    function automatic int to_width(input int unsigned n);
        int w;
        w = $clog2(n + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/cpu_seq_ctrl_if.sv
// Memory-side handshake of the sequencer: request, direction, address select
// and the completion strobe.
interface cpu_seq_ctrl_if;

    logic mem_req;
    logic mem_we;
    logic addr_sel;
    logic mem_rdy;

    modport master (
        output mem_req,
        output mem_we,
        output addr_sel,
        input  mem_rdy
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  addr_sel,
        output mem_rdy
    );

endinterface

// File: rtl/cpu_seq_ctrl_seq_mem_timer.sv
// Memory access watchdog: counts stalled request cycles and flags the last
// permitted one. MEM_TIMEOUT of 0 disables the flag.
module seq_mem_timer
    import cpu_seq_ctrl_pkg::*;
#(
    parameter  int unsigned MEM_TIMEOUT = 16,
    localparam int          TO_W        = to_width(MEM_TIMEOUT)
) (
    input  logic clock,
    input  logic n_rst,
    input  logic clr,
    input  logic en,
    output logic timeout
);

    localparam logic [TO_W-1:0] LAST =
        TO_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

    logic [TO_W-1:0] cnt;

    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    // en already excludes mem_rdy, so a completing access never times out.
    assign timeout = (MEM_TIMEOUT != 0) && en && (cnt == LAST);

endmodule

// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle control sequencer for the ONC-16 core: fetch, decode, then
// execute / memory / branch, with halt and sticky error handling.
module cpu_seq_ctrl
    import cpu_seq_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic               clock,
    input  logic               n_rst,
    cpu_seq_ctrl_if.master     bus,
    input  logic [OPC_W-1:0]   op_class,
    input  logic               bre,
    input  logic               run,
    output logic               ir_we,
    output logic               pc_inc,
    output logic               pc_load,
    output logic               de,
    output logic               flag_we,
    output logic               rf_we,
    output logic               halted,
    output logic               bus_err,
    output logic               ill_op,
    output logic [SEQ_W-1:0]   state
);

    seq_state_t       state_q;
    logic [OPC_W-1:0] op_q;
    logic             in_access;
    logic             to_en;
    logic             to_clr;
    logic             timeout;

    assign in_access = (state_q == SEQ_FETCH) || (state_q == SEQ_MEM);
    assign to_en     = in_access && !bus.mem_rdy;
    assign to_clr    = !in_access || bus.mem_rdy;

    seq_mem_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_timer (
        .clock   (clock),
        .n_rst   (n_rst),
        .clr     (to_clr),
        .en      (to_en),
        .timeout (timeout)
    );

    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= SEQ_IDLE;
            op_q    <= '0;
            bus_err <= 1'b0;
            ill_op  <= 1'b0;
        end else begin
            case (state_q)
                SEQ_IDLE: state_q <= SEQ_FETCH;
                SEQ_FETCH: begin
                    if (bus.mem_rdy) begin
                        state_q <= SEQ_DECODE;
                    end else if (timeout) begin
                        state_q <= SEQ_ERR;
                        bus_err <= 1'b1;
                    end
                end
                SEQ_DECODE: begin
                    op_q <= op_class;
                    case (op_class)
                        OPC_ALU:         state_q <= SEQ_EXEC;
                        OPC_LD, OPC_ST:  state_q <= SEQ_MEM;
                        OPC_BR:          state_q <= SEQ_BRANCH;
                        OPC_NOP:         state_q <= SEQ_FETCH;
                        OPC_HALT:        state_q <= SEQ_HALT;
                        default: begin
                            state_q <= SEQ_ERR;
                            ill_op  <= 1'b1;
                        end
                    endcase
                end
                SEQ_EXEC:   state_q <= SEQ_FETCH;
                SEQ_MEM: begin
                    if (bus.mem_rdy) begin
                        state_q <= SEQ_FETCH;
                    end else if (timeout) begin
                        state_q <= SEQ_ERR;
                        bus_err <= 1'b1;
                    end
                end
                SEQ_BRANCH: state_q <= SEQ_FETCH;
                SEQ_HALT: begin
                    if (run) begin
                        state_q <= SEQ_FETCH;
                    end
                end
                SEQ_ERR:    state_q <= SEQ_ERR;
                default:    state_q <= SEQ_ERR;
            endcase
        end
    end

    // Strobes decode straight from the state so an async reset kills them at once.
    always_comb begin
        ir_we        = 1'b0;
        pc_inc       = 1'b0;
        pc_load      = 1'b0;
        de           = 1'b0;
        flag_we      = 1'b0;
        rf_we        = 1'b0;
        halted       = 1'b0;
        bus.mem_req  = 1'b0;
        bus.mem_we   = 1'b0;
        bus.addr_sel = 1'b0;
        case (state_q)
            SEQ_FETCH: begin
                bus.mem_req = 1'b1;
                ir_we       = bus.mem_rdy;
                pc_inc      = bus.mem_rdy;
            end
            SEQ_EXEC: begin
                flag_we = 1'b1;
                rf_we   = 1'b1;
            end
            SEQ_MEM: begin
                bus.mem_req  = 1'b1;
                bus.addr_sel = 1'b1;
                bus.mem_we   = (op_q == OPC_ST);
                rf_we        = bus.mem_rdy && (op_q == OPC_LD);
            end
            SEQ_BRANCH: begin
                de      = 1'b1;
                pc_load = bre;
            end
            SEQ_HALT, SEQ_ERR: halted = 1'b1;
            default: ;
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Directed bench for cpu_seq_ctrl: a per-cycle vector table for the normal
// instruction flow plus hand-written timeout, reset and error sequences.
module tb_cpu_seq_ctrl;

    logic       clock;
    logic       n_rst;
    logic [2:0] op_class;
    logic       bre;
    logic       run;
    logic       ir_we, pc_inc, pc_load, de, flag_we, rf_we;
    logic       halted, bus_err, ill_op;
    logic [2:0] state;

    cpu_seq_ctrl_if bus ();

    cpu_seq_ctrl #(
        .MEM_TIMEOUT(4)
    ) dut (
        .clock    (clock),
        .n_rst    (n_rst),
        .bus      (bus),
        .op_class (op_class),
        .bre      (bre),
        .run      (run),
        .ir_we    (ir_we),
        .pc_inc   (pc_inc),
        .pc_load  (pc_load),
        .de       (de),
        .flag_we  (flag_we),
        .rf_we    (rf_we),
        .halted   (halted),
        .bus_err  (bus_err),
        .ill_op   (ill_op),
        .state    (state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // {ir_we, pc_inc, pc_load, de, flag_we, rf_we, mem_req, mem_we, addr_sel, halted, bus_err, ill_op}
    logic [11:0] act;
    assign act = {ir_we, pc_inc, pc_load, de, flag_we, rf_we,
                  bus.mem_req, bus.mem_we, bus.addr_sel, halted, bus_err, ill_op};

    localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
                           S_MEM = 3'd4, S_BRANCH = 3'd5, S_HALT = 3'd6, S_ERR = 3'd7;

    localparam logic [11:0] O_NONE  = 12'h000, O_FWAIT = 12'h020, O_FRDY  = 12'hC20,
                            O_EXEC  = 12'h0C0, O_BR1   = 12'h300, O_BR0   = 12'h100,
                            O_LDW   = 12'h028, O_LDR   = 12'h068, O_ST    = 12'h038,
                            O_HALT  = 12'h004, O_ERRIL = 12'h005, O_ERRBS = 12'h006;

    typedef struct {
        logic [2:0]  op;
        logic        rdy;
        logic        bre;
        logic        run;
        logic [2:0]  st;
        logic [11:0] outs;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   fails  = 0;

    task automatic add(input logic [2:0] op, input logic rdy, input logic b, input logic r,
                       input logic [2:0] st, input logic [11:0] outs);
        vec_t v;
        v.op = op; v.rdy = rdy; v.bre = b; v.run = r; v.st = st; v.outs = outs;
        tbl.push_back(v);
    endtask

    task automatic check(input string nm, input logic [2:0] st, input logic [11:0] outs);
        checks++;
        if (state !== st) begin
            fails++;
            $display("FAIL %s state: got %0d, expected %0d", nm, state, st);
        end
        checks++;
        if (act !== outs) begin
            fails++;
            $display("FAIL %s outputs: got %03h, expected %03h", nm, act, outs);
        end
    endtask

    task automatic step(input logic [2:0] op, input logic rdy, input logic b, input logic r,
                        input logic [2:0] st, input logic [11:0] outs, input string nm);
        @(negedge clock);
        op_class    = op;
        bus.mem_rdy = rdy;
        bre         = b;
        run         = r;
        #1;
        check(nm, st, outs);
    endtask

    task automatic do_reset();
        @(negedge clock);
        n_rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(3'd0, 1'b0, 1'b0, 1'b0, S_IDLE, O_NONE, $sformatf("reset[%0d]", i));
        end
        n_rst = 1'b1;
    endtask

    initial begin
        n_rst       = 1'b0;
        op_class    = '0;
        bus.mem_rdy = 1'b0;
        bre         = 1'b0;
        run         = 1'b0;

        // ALU: one fetch wait then ready, decode, exec
        add(3'd0, 0, 0, 0, S_FETCH,  O_FWAIT);
        add(3'd0, 1, 0, 0, S_FETCH,  O_FRDY);
        add(3'd0, 0, 0, 0, S_DECODE, O_NONE);
        add(3'd0, 0, 0, 0, S_EXEC,   O_EXEC);
        // Branch taken
        add(3'd0, 1, 1, 0, S_FETCH,  O_FRDY);
        add(3'd3, 0, 1, 0, S_DECODE, O_NONE);
        add(3'd0, 0, 1, 0, S_BRANCH, O_BR1);
        // Branch not taken; bre high outside BRANCH must be ignored
        add(3'd0, 1, 1, 0, S_FETCH,  O_FRDY);
        add(3'd3, 0, 1, 0, S_DECODE, O_NONE);
        add(3'd0, 0, 0, 0, S_BRANCH, O_BR0);
        // Load, ready on 4th MEM cycle; op_class changes to prove the latch
        add(3'd0, 1, 1, 0, S_FETCH,  O_FRDY);
        add(3'd1, 0, 1, 0, S_DECODE, O_NONE);
        add(3'd2, 0, 0, 0, S_MEM,    O_LDW);
        add(3'd2, 0, 0, 0, S_MEM,    O_LDW);
        add(3'd2, 0, 0, 0, S_MEM,    O_LDW);
        add(3'd2, 1, 0, 0, S_MEM,    O_LDR);
        // Store, ready on 4th MEM cycle
        add(3'd0, 1, 0, 0, S_FETCH,  O_FRDY);
        add(3'd2, 0, 0, 0, S_DECODE, O_NONE);
        add(3'd1, 0, 0, 0, S_MEM,    O_ST);
        add(3'd1, 0, 0, 0, S_MEM,    O_ST);
        add(3'd1, 0, 0, 0, S_MEM,    O_ST);
        add(3'd1, 1, 0, 0, S_MEM,    O_ST);
        // NOP then HALT and restart
        add(3'd0, 1, 0, 0, S_FETCH,  O_FRDY);
        add(3'd4, 0, 0, 0, S_DECODE, O_NONE);
        add(3'd0, 1, 0, 0, S_FETCH,  O_FRDY);
        add(3'd5, 0, 0, 0, S_DECODE, O_NONE);
        add(3'd0, 0, 0, 0, S_HALT,   O_HALT);
        add(3'd0, 0, 0, 1, S_HALT,   O_HALT);
        // Illegal op class: terminal error, run ignored
        add(3'd0, 1, 0, 0, S_FETCH,  O_FRDY);
        add(3'd7, 0, 0, 0, S_DECODE, O_NONE);
        add(3'd0, 0, 0, 1, S_ERR,    O_ERRIL);
        add(3'd0, 0, 0, 0, S_ERR,    O_ERRIL);

        do_reset();
        foreach (tbl[i]) begin
            step(tbl[i].op, tbl[i].rdy, tbl[i].bre, tbl[i].run, tbl[i].st, tbl[i].outs,
                 $sformatf("tbl[%0d]", i));
        end

        // Fetch timeout: mem_req for exactly 4 cycles, then sticky bus error
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(3'd0, 0, 0, 0, S_FETCH, O_FWAIT, $sformatf("to_wait[%0d]", i));
        end
        step(3'd0, 0, 0, 1, S_ERR, O_ERRBS, "to_err_run");
        step(3'd0, 0, 0, 0, S_ERR, O_ERRBS, "to_err_hold");

        // mem_rdy on the 4th cycle completes normally
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(3'd0, 0, 0, 0, S_FETCH, O_FWAIT, $sformatf("late_wait[%0d]", i));
        end
        step(3'd0, 1, 0, 0, S_FETCH,  O_FRDY, "late_rdy");
        step(3'd4, 0, 0, 0, S_DECODE, O_NONE, "late_decode");
        step(3'd0, 0, 0, 0, S_FETCH,  O_FWAIT, "late_refetch");

        // Async reset mid-access drops mem_req before any clock edge
        #2;
        n_rst = 1'b0;
        #1;
        check("async_rst", S_IDLE, O_NONE);
        do_reset();
        step(3'd0, 0, 0, 0, S_FETCH, O_FWAIT, "post_rst_fetch");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
